occupancy_scanner: RTL and testbench

OCCUPANCY_SCANNER -- requirements
Module: occupancy_scanner

---
 rtl/boids_pkg.sv | 23 ++
 rtl/hit_fifo2.sv | 63 ++++++
 rtl/occupancy_scanner.sv | 139 +++++++++++++
 tb/tb_occupancy_scanner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boids_pkg.sv
// Shared definitions for the occupancy scanner: FSM state encoding and
// helpers that split a flat cell address into its x (low) and y (high) parts.
package boids_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    DRAIN  = 3'd2,
    SWAP   = 3'd3,
    FINISH = 3'd4
  } scan_state_e;

  // x is the low row_bits bits of the address.
  function automatic logic [31:0] addr_to_x(input logic [31:0] addr, input int row_bits);
    return addr & ((32'd1 << row_bits) - 32'd1);
  endfunction

  // y is everything above the low row_bits bits.
  function automatic logic [31:0] addr_to_y(input logic [31:0] addr, input int row_bits);
    return addr >> row_bits;
  endfunction

endpackage

// File: rtl/hit_fifo2.sv
// Two-entry FIFO holding addresses of occupied cells until the consumer
// takes them. A push into a full FIFO is only accepted alongside a pop.
module hit_fifo2 #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  do_push, do_pop;

  // Next-state for storage, pointers and occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state register, cleared to empty with zeroed storage on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/occupancy_scanner.sv
// Scans every cell of an occupancy RAM once per frame, streams the (x,y) of
// each occupied cell out through a small FIFO, then pulses the RAM buffer
// swap and signals end of frame. Reads are throttled so that the FIFO plus
// the single in-flight read never exceed two entries.
module occupancy_scanner
  import boids_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int ROW_BITS   = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic                           rd_data,
  output logic                           swap,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ROW_BITS-1:0]            out_x,
  output logic [ADDR_WIDTH-ROW_BITS-1:0] out_y,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH:0]            hit_count
);

  localparam int Y_BITS = ADDR_WIDTH - ROW_BITS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   MAX_HITS  = (ADDR_WIDTH + 1)'(DEPTH);

  scan_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]   tag_q, tag_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH:0]     hit_count_q, hit_count_d;

  logic                    issue;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_valid;
  logic [1:0]              fifo_count;
  logic [ADDR_WIDTH-1:0]   fifo_head;

  // A returning read carries its tag into the FIFO only if the cell is set.
  assign fifo_push = inflight_q && rd_data;
  assign fifo_pop  = fifo_valid && out_ready;

  hit_fifo2 #(
    .WIDTH(ADDR_WIDTH)
  ) u_hit_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(tag_q),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .valid    (fifo_valid),
    .count    (fifo_count)
  );

  // Read issue, hit accounting and frame sequencing.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hit_count_d = hit_count_q;
    issue       = (state_q == SCAN) &&
                  (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2);
    inflight_d  = issue;
    tag_d       = issue ? ptr_q : tag_q;
    rd_addr_d   = issue ? ptr_q : rd_addr_q;

    if (fifo_pop && (hit_count_q < MAX_HITS)) begin
      hit_count_d = hit_count_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SCAN;
          ptr_d       = '0;
          hit_count_d = '0;
        end
      end
      SCAN: begin
        if (issue) begin
          if (ptr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && !fifo_valid) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scanner state register; reset abandons any frame and any in-flight read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      inflight_q  <= 1'b0;
      tag_q       <= '0;
      rd_addr_q   <= '0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      rd_addr_q   <= rd_addr_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign rd_addr   = rd_addr_d;
  assign swap      = (state_q == SWAP);
  assign done      = (state_q == FINISH);
  assign busy      = (state_q != IDLE);
  assign out_valid = fifo_valid;
  assign out_x     = ROW_BITS'(addr_to_x(32'(fifo_head), ROW_BITS));
  assign out_y     = Y_BITS'(addr_to_y(32'(fifo_head), ROW_BITS));
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_occupancy_scanner.sv
// Scoreboard bench for the occupancy scanner on a 16-cell (4x4) map with a
// one-cycle registered RAM model.
module tb_occupancy_scanner;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int RB    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          rd_data = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] rd_addr;
  logic          swap;
  logic          out_valid;
  logic [RB-1:0] out_x;
  logic [AW-RB-1:0] out_y;
  logic          busy;
  logic          done;
  logic [AW:0]   hit_count;

  logic [DEPTH-1:0] ram_bits = '0;

  int checks = 0;
  int errors = 0;
  int swap_cnt = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int stall_at = 4;
  int drv_cyc = 0;
  int exp_x[$];
  int exp_y[$];
  logic prev_swap = 1'b0;
  logic stalled = 1'b0;
  logic [RB-1:0] held_x = '0;
  logic [AW-RB-1:0] held_y = '0;
  logic [AW-1:0] held_addr = '0;

  occupancy_scanner #(
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW),
    .ROW_BITS(RB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .swap     (swap),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_y    (out_y),
    .busy     (busy),
    .done     (done),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // Occupancy RAM model: data for an address appears one cycle after it is presented.
  always @(posedge clk) rd_data <= ram_bits[rd_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Consumer model: drives out_ready each cycle according to the current mode.
  initial begin
    forever begin
      @(posedge clk);
      if (start) drv_cyc = 0;
      else drv_cyc++;
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: begin
          out_ready = !(drv_cyc >= stall_at && drv_cyc < stall_at + 20);
          if (drv_cyc == stall_at + 10) held_addr = rd_addr;
          if (drv_cyc == stall_at + 19) begin
            checkOutput("stall_rd_addr_hold", 32'(rd_addr), 32'(held_addr));
            checkOutput("stall_fifo_holds", 32'(out_valid), 1);
            checkOutput("stall_no_swap", 32'(swap), 0);
          end
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted hit and watches frame pulses.
  always @(negedge clk) begin
    if (!reset) begin
      stalled   = 1'b0;
      prev_swap = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("stall_valid_kept", 32'(out_valid), 1);
        checkOutput("stall_x_stable", 32'(out_x), 32'(held_x));
        checkOutput("stall_y_stable", 32'(out_y), 32'(held_y));
      end
      if (out_valid && out_ready) begin
        if (exp_x.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_hit: got x=%0d y=%0d expected none", out_x, out_y);
        end else begin
          int ex;
          int ey;
          ex = exp_x.pop_front();
          ey = exp_y.pop_front();
          checkOutput("hit_x", 32'(out_x), 32'(ex));
          checkOutput("hit_y", 32'(out_y), 32'(ey));
        end
      end
      stalled = out_valid && !out_ready;
      held_x  = out_x;
      held_y  = out_y;
      if (swap) begin
        swap_cnt++;
        checkOutput("drained_before_swap", 32'(exp_x.size()), 0);
      end
      if (done) begin
        done_cnt++;
        checkOutput("swap_precedes_done", 32'(prev_swap), 1);
      end
      prev_swap = swap;
    end
  end

  // Runs one frame over the given map and checks the frame-level results.
  task automatic applyStimulus(input string tag, input logic [DEPTH-1:0] bits, input int mode,
                               input int exp_hits, input bit check_len, input int extra_start_at);
    int cyc;
    bit got_done;
    ram_bits   = bits;
    ready_mode = mode;
    swap_cnt   = 0;
    done_cnt   = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (bits[a]) begin
        exp_x.push_back(a % 4);
        exp_y.push_back(a / 4);
      end
    end
    $display("[TB] frame %s", tag);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    got_done = 1'b0;
    while (cyc < 200 && !got_done) begin
      @(negedge clk);
      if (cyc == 1) checkOutput("first_read_addr", 32'(rd_addr), 0);
      if (cyc == 2) checkOutput("second_read_addr", 32'(rd_addr), 1);
      if (done) begin
        got_done = 1'b1;
      end else if (cyc == extra_start_at) begin
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc += 2;
      end else begin
        cyc++;
      end
    end
    if (!got_done) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done expected done within 200 cycles");
    end else begin
      if (check_len) checkOutput("frame_len_within_one_of_20", 32'(cyc >= 19 && cyc <= 21), 1);
      checkOutput("hit_count_at_done", 32'(hit_count), 32'(exp_hits));
      checkOutput("busy_in_finish", 32'(busy), 1);
      @(negedge clk);
      checkOutput("busy_after_done", 32'(busy), 0);
      checkOutput("done_one_cycle", 32'(done), 0);
      repeat (3) @(negedge clk);
      checkOutput("swap_count", 32'(swap_cnt), 1);
      checkOutput("done_count", 32'(done_cnt), 1);
      checkOutput("hits_outstanding", 32'(exp_x.size()), 0);
      checkOutput("hit_count_holds", 32'(hit_count), 32'(exp_hits));
    end
    exp_x.delete();
    exp_y.delete();
    ready_mode = 0;
  endtask

  // Aborts a frame with the read pointer stalled at 7 and checks reset behaviour.
  task automatic resetMidFrame();
    int n;
    ram_bits   = 16'h0060;
    ready_mode = 3;
    swap_cnt   = 0;
    done_cnt   = 0;
    $display("[TB] frame reset_mid_frame");
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reset_frame_hit_seen", 32'(out_valid), 1);
    repeat (4) @(negedge clk);
    checkOutput("stalled_rd_addr", 32'(rd_addr), 6);
    checkOutput("busy_before_reset", 32'(busy), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_rd_addr", 32'(rd_addr), 0);
    checkOutput("rst_swap", 32'(swap), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_x", 32'(out_x), 0);
    checkOutput("rst_out_y", 32'(out_y), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_hit_count", 32'(hit_count), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    ready_mode = 0;
    repeat (6) @(negedge clk);
    checkOutput("no_swap_after_abort", 32'(swap_cnt), 0);
    checkOutput("no_done_after_abort", 32'(done_cnt), 0);
    checkOutput("idle_after_abort", 32'(busy), 0);
    checkOutput("no_stale_hit", 32'(out_valid), 0);
  endtask

  initial begin
    #1;
    checkOutput("init_rd_addr", 32'(rd_addr), 0);
    checkOutput("init_out_valid", 32'(out_valid), 0);
    checkOutput("init_busy", 32'(busy), 0);
    checkOutput("init_done", 32'(done), 0);
    checkOutput("init_swap", 32'(swap), 0);
    checkOutput("init_hit_count", 32'(hit_count), 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    applyStimulus("empty_map",        16'h0000, 0, 0,  1'b1, 0);
    applyStimulus("sparse_0_5_15",    16'h8021, 0, 3,  1'b0, 0);
    applyStimulus("full_toggle",      16'hFFFF, 1, 16, 1'b0, 0);
    applyStimulus("stall_20",         16'hFF3C, 2, 12, 1'b0, 0);
    applyStimulus("start_while_busy", 16'h0108, 0, 2,  1'b0, 6);
    resetMidFrame();
    applyStimulus("rescan_after_rst", 16'h0003, 0, 2,  1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
